// File: rtl/pg_pattern_ctrl_pkg.sv
// Shared types and default widths for the pattern-generator control block.
// Imported by the top-level controller and by the key debouncer.
package pg_pattern_ctrl_pkg;

    localparam int DEB_W     = 20;
    localparam int FRM_W     = 8;
    localparam int DEF_IDX_W = 4;

    // Key slots in the key/press vectors
    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_SEL  = 2;
    localparam int KEY_AUTO = 3;
    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_HOLD   = 2'd2
    } pg_state_e;

endpackage

// File: rtl/pg_key_debounce.sv
// One push-button path: 2-flop synchronizer, stable-sample debounce counter,
// and a rising-edge detector that yields a single-cycle press pulse.
module pg_key_debounce
    import pg_pattern_ctrl_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so bounces never accumulate.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_CYCLES - 20'd1) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/pg_pattern_ctrl.sv
// Pattern selection controller: MANUAL/AUTO/HOLD mode FSM, wrapping pattern
// index arithmetic, auto-advance frame counter and frame-aligned index load.
module pg_pattern_ctrl
    import pg_pattern_ctrl_pkg::*;
#(
    parameter logic [7:0]       PAT_NUM     = 8'd16,
    parameter int               IDX_W       = DEF_IDX_W,
    parameter logic [DEB_W-1:0] DEB_CYCLES  = 20'd1000000,
    parameter logic [FRM_W-1:0] AUTO_FRAMES = 8'd60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             key_up,
    input  logic             key_down,
    input  logic             key_sel,
    input  logic             key_auto,
    input  logic             pg_frm_st,
    output logic [IDX_W-1:0] pat_idx,
    output logic             pat_upd,
    output logic             auto_mode,
    output logic             hold_mode
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_NUM - 8'd1);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] ev;
    logic                up_ev;
    logic                dn_ev;
    logic                sel_ev;
    logic                aut_ev;
    logic                frm;
    logic                adv;
    logic [IDX_W-1:0]    base_idx;

    pg_state_e           state_q;
    pg_state_e           state_d;
    logic [IDX_W-1:0]    next_idx_q;
    logic [IDX_W-1:0]    next_idx_d;
    logic [IDX_W-1:0]    pat_idx_q;
    logic [IDX_W-1:0]    pat_idx_d;
    logic                pat_upd_q;
    logic                pat_upd_d;
    logic [FRM_W-1:0]    fcnt_q;
    logic [FRM_W-1:0]    fcnt_d;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_MAX) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] v);
        return (v == '0) ? IDX_MAX : v - 1'b1;
    endfunction

    assign key_raw[KEY_UP]   = key_up;
    assign key_raw[KEY_DOWN] = key_down;
    assign key_raw[KEY_SEL]  = key_sel;
    assign key_raw[KEY_AUTO] = key_auto;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            pg_key_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .rst_n   (rst_n),
                .key_i   (key_raw[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    // Gating the events (not the debouncers) freezes everything while en=0
    // and drops any press whose edge lands in that window.
    assign ev     = press & {NUM_KEYS{en}};
    assign frm    = pg_frm_st & en;
    assign up_ev  = ev[KEY_UP] & ~ev[KEY_DOWN];
    assign dn_ev  = ev[KEY_DOWN] & ~ev[KEY_UP];
    assign sel_ev = ev[KEY_SEL];
    assign aut_ev = ev[KEY_AUTO];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MANUAL: begin
                if (sel_ev)      state_d = ST_HOLD;
                else if (aut_ev) state_d = ST_AUTO;
            end
            ST_AUTO: begin
                if (sel_ev)      state_d = ST_HOLD;
                else if (aut_ev) state_d = ST_MANUAL;
            end
            ST_HOLD: begin
                if (sel_ev)      state_d = ST_MANUAL;
            end
            default:             state_d = ST_MANUAL;
        endcase
    end

    always_comb begin
        auto_mode = (state_q == ST_AUTO);
        hold_mode = (state_q == ST_HOLD);
    end

    // base_idx is the frame-start view of next_idx (auto advance included);
    // a coincident press is layered on top so it only shows at the next load.
    always_comb begin
        adv        = (state_q == ST_AUTO) && frm && (fcnt_q == AUTO_FRAMES - 8'd1);
        base_idx   = adv ? idx_inc(next_idx_q) : next_idx_q;
        next_idx_d = base_idx;
        fcnt_d     = fcnt_q;
        pat_idx_d  = pat_idx_q;
        pat_upd_d  = 1'b0;

        if ((state_q == ST_AUTO) && frm) begin
            fcnt_d = adv ? '0 : fcnt_q + 1'b1;
        end

        if (state_q != ST_HOLD) begin
            if (up_ev)      next_idx_d = idx_inc(base_idx);
            else if (dn_ev) next_idx_d = idx_dec(base_idx);
            if ((state_q == ST_AUTO) && (up_ev || dn_ev)) begin
                fcnt_d = '0;
            end
        end

        if ((state_q == ST_MANUAL) && (state_d == ST_AUTO)) begin
            fcnt_d = '0;
        end

        if (frm) begin
            pat_idx_d = base_idx;
            pat_upd_d = (base_idx != pat_idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            next_idx_q <= '0;
            pat_idx_q  <= '0;
            pat_upd_q  <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            next_idx_q <= next_idx_d;
            pat_idx_q  <= pat_idx_d;
            pat_upd_q  <= pat_upd_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign pat_idx = pat_idx_q;
    assign pat_upd = pat_upd_q;

endmodule

// File: tb/tb_pg_pattern_ctrl.sv
// Directed plus randomized bench for pg_pattern_ctrl with a press/frame
// level reference model (PAT_NUM=5, DEB_CYCLES=4, AUTO_FRAMES=3).
module tb_pg_pattern_ctrl;

    localparam int NPAT = 5;
    localparam int DEB  = 4;
    localparam int AFR  = 3;
    localparam int GAP  = 12;
    // key drive (before edge 1) -> press seen by the controller at edge 2+DEB+1
    localparam int PRESS_LAT = 2 + DEB + 1;

    localparam int M_MANUAL = 0;
    localparam int M_AUTO   = 1;
    localparam int M_HOLD   = 2;

    localparam bit [3:0] K_UP   = 4'b0001;
    localparam bit [3:0] K_DN   = 4'b0010;
    localparam bit [3:0] K_SEL  = 4'b0100;
    localparam bit [3:0] K_AUTO = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic       key_sel = 1'b0;
    logic       key_auto = 1'b0;
    logic       pg_frm_st = 1'b0;
    logic [2:0] pat_idx;
    logic       pat_upd;
    logic       auto_mode;
    logic       hold_mode;

    int n_checks = 0;
    int n_pass   = 0;

    int m_state = M_MANUAL;
    int m_next  = 0;
    int m_pat   = 0;
    int m_cnt   = 0;
    int m_upd   = 0;

    pg_pattern_ctrl #(
        .PAT_NUM     (8'd5),
        .IDX_W       (3),
        .DEB_CYCLES  (20'd4),
        .AUTO_FRAMES (8'd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_sel   (key_sel),
        .key_auto  (key_auto),
        .pg_frm_st (pg_frm_st),
        .pat_idx   (pat_idx),
        .pat_upd   (pat_upd),
        .auto_mode (auto_mode),
        .hold_mode (hold_mode)
    );

    always #5 clk = ~clk;

    function automatic int wrap_up(input int v);
        return (v + 1) % NPAT;
    endfunction

    function automatic int wrap_dn(input int v);
        return (v + NPAT - 1) % NPAT;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".pat_idx"}, int'(pat_idx), m_pat);
        chk({tag, ".pat_upd"}, int'(pat_upd), m_upd);
        chk({tag, ".auto"}, int'(auto_mode), (m_state == M_AUTO) ? 1 : 0);
        chk({tag, ".hold"}, int'(hold_mode), (m_state == M_HOLD) ? 1 : 0);
    endtask

    // Reference: effect of one accepted press set on mode and next index
    task automatic m_press(input bit [3:0] mask);
        bit up_v;
        bit dn_v;
        up_v = mask[0] && !mask[1];
        dn_v = mask[1] && !mask[0];
        if (m_state != M_HOLD && (up_v || dn_v)) begin
            m_next = up_v ? wrap_up(m_next) : wrap_dn(m_next);
            if (m_state == M_AUTO) m_cnt = 0;
        end
        if (mask[2]) begin
            m_state = (m_state == M_HOLD) ? M_MANUAL : M_HOLD;
        end else if (mask[3]) begin
            if (m_state == M_MANUAL) begin
                m_state = M_AUTO;
                m_cnt   = 0;
            end else if (m_state == M_AUTO) begin
                m_state = M_MANUAL;
            end
        end
    endtask

    // Reference: one accepted frame start
    task automatic m_frame();
        int old;
        old = m_pat;
        if (m_state == M_AUTO) begin
            if (m_cnt == AFR - 1) begin
                m_cnt  = 0;
                m_next = wrap_up(m_next);
            end else begin
                m_cnt++;
            end
        end
        m_pat = m_next;
        m_upd = (m_pat != old) ? 1 : 0;
    endtask

    task automatic set_keys(input bit [3:0] mask);
        key_up   = mask[0];
        key_down = mask[1];
        key_sel  = mask[2];
        key_auto = mask[3];
    endtask

    task automatic do_press(input string tag, input bit [3:0] mask, input int hold, input bit en_v);
        @(negedge clk);
        en = en_v;
        set_keys(mask);
        repeat (hold) @(negedge clk);
        set_keys(4'b0000);
        repeat (GAP) @(negedge clk);
        en = 1'b1;
        if (en_v && hold >= DEB) m_press(mask);
        m_upd = 0;
        $display("press %s mask=%b hold=%0d en=%0b -> auto=%0b hold=%0b", tag, mask, hold, en_v,
                 auto_mode, hold_mode);
        chk({tag, ".auto"}, int'(auto_mode), (m_state == M_AUTO) ? 1 : 0);
        chk({tag, ".hold"}, int'(hold_mode), (m_state == M_HOLD) ? 1 : 0);
    endtask

    task automatic do_frame(input string tag, input bit en_v);
        @(negedge clk);
        en = en_v;
        pg_frm_st = 1'b1;
        @(negedge clk);
        pg_frm_st = 1'b0;
        if (en_v) m_frame();
        else m_upd = 0;
        $display("frame %s en=%0b -> pat_idx=%0d pat_upd=%0b", tag, en_v, pat_idx, pat_upd);
        chk_outputs(tag);
        @(negedge clk);
        en = 1'b1;
        chk({tag, ".upd_pulse"}, int'(pat_upd), 0);
        m_upd = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        set_keys(4'b0000);
        pg_frm_st = 1'b0;
        @(negedge clk);
        m_state = M_MANUAL;
        m_next  = 0;
        m_pat   = 0;
        m_cnt   = 0;
        m_upd   = 0;
        $display("reset %s -> pat_idx=%0d pat_upd=%0b auto=%0b hold=%0b", tag, pat_idx, pat_upd,
                 auto_mode, hold_mode);
        chk_outputs(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        bit [3:0] mask;
        int       act;
        int       hold;
        bit       en_v;

        // Reset state
        repeat (3) @(negedge clk);
        do_reset("reset");

        // Bounce: a 3-cycle blip is rejected, a 10-cycle hold is one press
        do_press("bounce_short", K_UP, 3, 1'b1);
        do_press("bounce_long", K_UP, 10, 1'b1);
        do_frame("bounce_frame", 1'b1);
        do_frame("bounce_nochg", 1'b1);

        // Wrap in both directions
        do_reset("wrap_reset");
        do_press("wrap_down", K_DN, 6, 1'b1);
        do_frame("wrap_frame1", 1'b1);
        do_press("wrap_up1", K_UP, 6, 1'b1);
        do_press("wrap_up2", K_UP, 6, 1'b1);
        do_frame("wrap_frame2", 1'b1);

        // Auto advance every third frame start
        do_press("auto_on", K_AUTO, 6, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            do_frame($sformatf("auto_f%0d", i), 1'b1);
        end

        // Hold freezes index and frame count
        do_frame("auto_f10", 1'b1);
        do_press("hold_on", K_SEL, 6, 1'b1);
        for (int i = 1; i <= 6; i++) begin
            do_frame($sformatf("hold_f%0d", i), 1'b1);
            if (i == 3) do_press("hold_up", K_UP, 6, 1'b1);
        end
        do_press("hold_auto_ignored", K_AUTO, 6, 1'b1);
        do_press("hold_off", K_SEL, 6, 1'b1);
        do_frame("manual_after_hold", 1'b1);

        // Simultaneous up/down cancel
        do_press("both", K_UP | K_DN, 6, 1'b1);
        do_frame("both_frame", 1'b1);

        // Up press landing in the same cycle as a frame start
        @(negedge clk);
        key_up = 1'b1;
        repeat (PRESS_LAT - 1) @(negedge clk);
        pg_frm_st = 1'b1;
        @(negedge clk);
        pg_frm_st = 1'b0;
        m_frame();
        m_press(K_UP);
        $display("frame coincide -> pat_idx=%0d pat_upd=%0b", pat_idx, pat_upd);
        chk_outputs("coincide");
        key_up = 1'b0;
        repeat (GAP) @(negedge clk);
        do_frame("coincide_next", 1'b1);

        // Enable low swallows presses and frame starts
        do_press("en_off_press", K_UP, 6, 1'b0);
        do_frame("en_off_frame", 1'b0);
        do_frame("en_on_frame", 1'b1);

        // Reset mid auto count and mid debounce
        do_press("auto_again", K_AUTO, 6, 1'b1);
        do_press("auto_up", K_UP, 6, 1'b1);
        do_frame("auto_cnt1", 1'b1);
        @(negedge clk);
        key_up = 1'b1;
        repeat (2) @(negedge clk);
        do_reset("mid_reset");
        repeat (GAP) @(negedge clk);
        do_frame("post_reset", 1'b1);

        // Randomized press / frame mix
        for (int n = 0; n < 70; n++) begin
            act  = int'($urandom_range(0, 11));
            hold = int'($urandom_range(1, 7));
            en_v = ($urandom_range(0, 5) != 0);
            case (act)
                0, 1, 2: mask = K_UP;
                3, 4:    mask = K_DN;
                5:       mask = K_UP | K_DN;
                6:       mask = K_SEL;
                7:       mask = K_AUTO;
                default: mask = 4'b0000;
            endcase
            if (mask == 4'b0000) do_frame($sformatf("rnd%0d", n), en_v);
            else do_press($sformatf("rnd%0d", n), mask, hold, en_v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
